// File: rtl/jt12_out_pkg.sv
// Shared types, constants and the gain/saturate helper for the FM output stage.
// Pure combinational helpers; no latency or flow control here.
package jt12_out_pkg;

  localparam logic [15:0] SAT_POS   = 16'h7FFF;
  localparam logic [15:0] SAT_NEG   = 16'h8000;
  localparam logic [2:0]  GAIN_MAX  = 3'd4;
  localparam int          DEPTH_DEF = 4;
  localparam int          OVFW_DEF  = 8;

  localparam logic signed [16:0] LIM_POS = 17'sd32767;
  localparam logic signed [16:0] LIM_NEG = -17'sd32768;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } frame_t;

  // Shift a 12-bit signed sample left by min(gain,4) and clamp to 16-bit signed.
  function automatic logic [15:0] apply_gain(input logic [11:0] x, input logic [2:0] gain);
    logic [2:0]         sh;
    logic signed [16:0] x17;
    sh  = (gain > GAIN_MAX) ? GAIN_MAX : gain;
    x17 = $signed({{5{x[11]}}, x}) <<< sh;
    if (x17 > LIM_POS)      return SAT_POS;
    else if (x17 < LIM_NEG) return SAT_NEG;
    else                    return x17[15:0];
  endfunction

endpackage

// File: rtl/jt12_out_fifo.sv
// Generic first-word-fall-through FIFO: a push is visible at dout the cycle after it lands.
// Backpressure: push on full is ignored unless a pop frees the slot that cycle; dout reads 0 when empty.
module jt12_out_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jt12_out_stage.sv
// FM output stage: edge-captured stereo frame -> gain/saturate/mute -> FWFT FIFO; head valid one cycle after capture.
// Backpressure: head held while out_ready is low; captures arriving on a full FIFO are dropped and counted.
module jt12_out_stage
  import jt12_out_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int OVFW  = OVFW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic [11:0]     left,
  input  logic [11:0]     right,
  input  logic            sample,
  input  logic [2:0]      gain,
  input  logic            mute,
  output logic [15:0]     out_left,
  output logic [15:0]     out_right,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            ovf,
  input  logic            ovf_clr,
  output logic [OVFW-1:0] ovf_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          sample_d;
  logic          push, pop, drop;
  logic          full, empty;
  logic [CW-1:0] fifo_cnt;
  frame_t        wr_frame, head;

  assign push = clk_en && sample && !sample_d;
  assign pop  = out_valid && out_ready;
  assign drop = push && full && !pop;

  always_comb begin
    wr_frame = '0;
    if (!mute) begin
      wr_frame.left  = apply_gain(left, gain);
      wr_frame.right = apply_gain(right, gain);
    end
  end

  jt12_out_fifo #(
    .WIDTH ($bits(frame_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (wr_frame),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  assign out_valid = !empty;
  assign out_left  = head.left;
  assign out_right = head.right;

  // sample_d resets high so a sample line already high after reset is not taken as an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_d <= 1'b1;
      ovf      <= 1'b0;
      ovf_cnt  <= '0;
    end else begin
      if (clk_en) sample_d <= sample;
      if (ovf_clr) begin
        ovf     <= 1'b0;
        ovf_cnt <= '0;
      end else if (drop) begin
        ovf <= 1'b1;
        if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
      end
    end
  end

  a_full_cnt: assert property (@(posedge clk) disable iff (!rst_n)
                               full == (fifo_cnt == CW'(DEPTH)));

endmodule
